ecc_scrubber: RTL

Background ECC scrubber for the 13-bit Hamming-protected memory path. On each `start` pulse it sweeps addresses 0..DEPTH-1, reads every stored codeword, and classifies it as clean, correctable or uncorrectable. It writes corrected codewords back in place and counts errors. It is the reader/repair end for codewords produced by the `hamming_encoder` write path.

---
 rtl/ecc_pkg.sv | 21 ++
 rtl/hamming13_check.sv | 34 +++
 rtl/ecc_scrubber.sv | 106 ++++++++++
 3 files changed

// File: rtl/ecc_pkg.sv
// Shared types and widths for the 13-bit Hamming scrubber path.
package ecc_pkg;

    localparam int unsigned CODE_W = 13;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StChk,
        StWr,
        StDone
    } scrub_state_e;

    typedef enum logic [1:0] {
        CLEAN,
        CORR,
        UNCORR
    } ecc_class_e;

endpackage

// File: rtl/hamming13_check.sv
// Combinational SECDED check of one 13-bit codeword: classifies it and
// produces the corrected codeword.
module hamming13_check
    import ecc_pkg::*;
(
    input  logic [12:0] code,
    output logic [1:0]  cls,
    output logic [12:0] corrected
);

    logic [3:0] syn;
    logic       par;

    always_comb begin
        syn[0] = code[1] ^ code[3] ^ code[5] ^ code[7] ^ code[9] ^ code[11];
        syn[1] = code[2] ^ code[3] ^ code[6] ^ code[7] ^ code[10] ^ code[11];
        syn[2] = code[4] ^ code[5] ^ code[6] ^ code[7] ^ code[12];
        syn[3] = code[8] ^ code[9] ^ code[10] ^ code[11] ^ code[12];
        par    = ^code;

        // syn==0 with par set flips code[0], so one shift covers both cases
        corrected = code;
        cls       = CLEAN;
        if (!par) begin
            if (syn != 4'd0) cls = UNCORR;
        end else if (syn <= 4'd12) begin
            corrected = code ^ (13'd1 << syn);
            cls       = CORR;
        end else begin
            cls = UNCORR;
        end
    end

endmodule

// File: rtl/ecc_scrubber.sv
// Background scrubber: sweeps 0..DEPTH-1, repairs single-bit errors in place
// and counts correctable / uncorrectable words.
module ecc_scrubber
    import ecc_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [12:0]       mem_wdata,
    input  logic [12:0]       mem_rdata,
    output logic [15:0]       corr_cnt,
    output logic [15:0]       uncorr_cnt,
    output logic              uncorr_flag,
    output logic [ADDR_W-1:0] last_uncorr_addr
);

    scrub_state_e      state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        cls;
    logic [12:0]       corrected;
    logic              last_word;

    hamming13_check u_check (
        .code      (mem_rdata),
        .cls       (cls),
        .corrected (corrected)
    );

    assign last_word = (addr_q == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            addr_q           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            corr_cnt         <= '0;
            uncorr_cnt       <= '0;
            uncorr_flag      <= 1'b0;
            last_uncorr_addr <= '0;
        end else begin
            done      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        corr_cnt         <= '0;
                        uncorr_cnt       <= '0;
                        uncorr_flag      <= 1'b0;
                        last_uncorr_addr <= '0;
                        addr_q           <= '0;
                        busy             <= 1'b1;
                        mem_req          <= 1'b1;
                        mem_addr         <= '0;
                        state_q          <= StRd;
                    end
                end
                StRd: state_q <= StChk;
                StChk, StWr: begin
                    if (state_q == StChk && cls == CORR) begin
                        if (corr_cnt != 16'hFFFF) corr_cnt <= corr_cnt + 16'd1;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_wdata <= corrected;
                        state_q   <= StWr;
                    end else begin
                        if (state_q == StChk && cls == UNCORR) begin
                            if (uncorr_cnt != 16'hFFFF) uncorr_cnt <= uncorr_cnt + 16'd1;
                            uncorr_flag      <= 1'b1;
                            last_uncorr_addr <= addr_q;
                        end
                        if (last_word) begin
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            addr_q   <= addr_q + 1'b1;
                            mem_req  <= 1'b1;
                            mem_addr <= addr_q + 1'b1;
                            state_q  <= StRd;
                        end
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
